// File: rtl/smem_pkg.sv
// Shared types and index-width helpers for the banked shared-memory unit.
package smem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RSP
   } state_t;

   function automatic int bank_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int row_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SMEM_BANKS     = 4;
   localparam int SMEM_ROWS      = 256;
   localparam int SMEM_BANK_BITS = bank_bits(SMEM_BANKS);
   localparam int SMEM_ROW_BITS  = row_bits(SMEM_ROWS);

endpackage

// File: rtl/smem_bank_sel.sv
// Per-bank lane selector: grants the lowest pending lane mapped to this bank.
// With SMEM_BCAST_EN, same-row pending reads ride along with a read grant.
module smem_bank_sel
   import smem_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int BANK_BITS = SMEM_BANK_BITS,
`ifdef SMEM_BCAST_EN
   parameter int ROW_BITS  = SMEM_ROW_BITS,
`endif
   parameter int BANK      = 0
) (
   input  logic [LANES-1:0]                pending,
   input  logic [LANES-1:0][BANK_BITS-1:0] bank_id,
`ifdef SMEM_BCAST_EN
   input  logic [LANES-1:0]                rw,
   input  logic [LANES-1:0][ROW_BITS-1:0]  row,
   output logic [LANES-1:0]                merge,
`endif
   output logic [LANES-1:0]                grant
);

   logic [LANES-1:0] match;

   always_comb begin
      match = '0;
      for (int i = 0; i < LANES; i++) begin
         match[i] = pending[i] && (bank_id[i] == BANK_BITS'(BANK));
      end
   end

   assign grant = match & (~match + LANES'(1));

`ifdef SMEM_BCAST_EN
   always_comb begin
      merge = grant;
      for (int g = 0; g < LANES; g++) begin
         if (grant[g] && !rw[g]) begin
            for (int i = 0; i < LANES; i++) begin
               if (match[i] && !rw[i] && row[i] == row[g]) begin
                  merge[i] = 1'b1;
               end
            end
         end
      end
   end
`endif

endmodule

// File: rtl/smem_bank_unit.sv
// Banked shared-memory storage: one batch per handshake, bank conflicts serialized.
// Optional SMEM_BCAST_EN merges same-word reads within a bank into one cycle.
module smem_bank_unit
   import smem_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int NUM_BANKS  = 4,
   parameter int WORD_SIZE  = 4,
   parameter int SIZE       = 4096,
   parameter int ADDR_WIDTH = 32 - $clog2(WORD_SIZE),
   parameter int TAG_WIDTH  = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [LANES-1:0]                      req_valid_in,
   input  logic [LANES-1:0]                      req_rw_in,
   input  logic [LANES-1:0][WORD_SIZE-1:0]       req_byteen_in,
   input  logic [LANES-1:0][ADDR_WIDTH-1:0]      req_addr_in,
   input  logic [LANES-1:0][8*WORD_SIZE-1:0]     req_data_in,
   input  logic [LANES-1:0][TAG_WIDTH-1:0]       req_tag_in,
   output logic [LANES-1:0]                      req_ready_in,
   output logic                                  rsp_valid_out,
   output logic [LANES-1:0]                      rsp_tmask_out,
   output logic [LANES-1:0][8*WORD_SIZE-1:0]     rsp_data_out,
   output logic [TAG_WIDTH-1:0]                  rsp_tag_out,
   input  logic                                  rsp_ready_out
);

   localparam int ROWS = SIZE / (WORD_SIZE * NUM_BANKS);
   localparam int BB   = bank_bits(NUM_BANKS);
   localparam int RB   = row_bits(ROWS);

   state_t state, state_n;

   logic [LANES-1:0]                  pending, pending_n, rmask, rw_r, served;
   logic [LANES-1:0][BB-1:0]          bank_r;
   logic [LANES-1:0][RB-1:0]          row_r;
   logic [LANES-1:0][WORD_SIZE-1:0]   byteen_r;
   logic [LANES-1:0][WORD_SIZE-1:0][7:0] wdata_r;
   logic [LANES-1:0][8*WORD_SIZE-1:0] rdata_r;
   logic [TAG_WIDTH-1:0]              tag_r, first_tag;
   logic [NUM_BANKS-1:0][LANES-1:0]   grant, serve;
   logic                              addr_unused;

   logic [WORD_SIZE-1:0][7:0] mem [NUM_BANKS][ROWS];

   assign addr_unused = ^req_addr_in;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      smem_bank_sel #(
         .LANES     (LANES),
         .BANK_BITS (BB),
`ifdef SMEM_BCAST_EN
         .ROW_BITS  (RB),
`endif
         .BANK      (b)
      ) u_sel (
         .pending (pending),
         .bank_id (bank_r),
`ifdef SMEM_BCAST_EN
         .rw      (rw_r),
         .row     (row_r),
         .merge   (serve[b]),
`endif
         .grant   (grant[b])
      );
`ifndef SMEM_BCAST_EN
      assign serve[b] = grant[b];
`endif
   end

   always_comb begin
      served = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         served = served | serve[b];
      end
      pending_n = pending & ~served;
   end

   always_comb begin
      first_tag = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (req_valid_in[i]) first_tag = req_tag_in[i];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (|req_valid_in) state_n = ACCESS;
         ACCESS:  if (pending_n == '0) state_n = (rmask != '0) ? RSP : IDLE;
         RSP:     if (rsp_ready_out) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending  <= '0;
         rmask    <= '0;
         rw_r     <= '0;
         bank_r   <= '0;
         row_r    <= '0;
         byteen_r <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
         tag_r    <= '0;
      end else if (state == IDLE) begin
         if (|req_valid_in) begin
            pending  <= req_valid_in;
            rmask    <= req_valid_in & ~req_rw_in;
            rw_r     <= req_rw_in;
            byteen_r <= req_byteen_in;
            wdata_r  <= req_data_in;
            rdata_r  <= '0;
            tag_r    <= first_tag;
            for (int i = 0; i < LANES; i++) begin
               bank_r[i] <= req_addr_in[i][BB-1:0];
               row_r[i]  <= req_addr_in[i][BB +: RB];
            end
         end
      end else if (state == ACCESS) begin
         pending <= pending_n;
         for (int i = 0; i < LANES; i++) begin
            if (served[i] && !rw_r[i]) rdata_r[i] <= mem[bank_r[i]][row_r[i]];
         end
      end
   end

   // Storage is never reset; only one lane per bank can hold a write grant.
   always_ff @(posedge clk) begin
      if (state == ACCESS) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < LANES; i++) begin
               if (grant[b][i] && rw_r[i]) begin
                  for (int j = 0; j < WORD_SIZE; j++) begin
                     if (byteen_r[i][j]) mem[b][row_r[i]][j] <= wdata_r[i][j];
                  end
               end
            end
         end
      end
   end

   assign req_ready_in  = {LANES{(state == IDLE) && reset}};
   assign rsp_valid_out = (state == RSP);
   assign rsp_tmask_out = rmask;
   assign rsp_data_out  = rdata_r;
   assign rsp_tag_out   = tag_r;

endmodule

// File: tb/tb_smem_bank_unit.sv
// Scoreboard bench for smem_bank_unit; builds with or without SMEM_BCAST_EN.
module tb_smem_bank_unit;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [3:0]        req_valid_in, req_rw_in, req_ready_in;
   logic [3:0][3:0]   req_byteen_in;
   logic [3:0][29:0]  req_addr_in;
   logic [3:0][31:0]  req_data_in, rsp_data_out;
   logic [3:0][7:0]   req_tag_in;
   logic              rsp_valid_out, rsp_ready_out;
   logic [3:0]        rsp_tmask_out;
   logic [7:0]        rsp_tag_out;

   typedef struct packed {
      logic [3:0]       tmask;
      logic [3:0][31:0] data;
      logic [7:0]       tag;
   } rsp_t;

   rsp_t        sb[$];
   logic [31:0] mdl [int];
   int          tests_run = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   smem_bank_unit dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid_in  (req_valid_in),
      .req_rw_in     (req_rw_in),
      .req_byteen_in (req_byteen_in),
      .req_addr_in   (req_addr_in),
      .req_data_in   (req_data_in),
      .req_tag_in    (req_tag_in),
      .req_ready_in  (req_ready_in),
      .rsp_valid_out (rsp_valid_out),
      .rsp_tmask_out (rsp_tmask_out),
      .rsp_data_out  (rsp_data_out),
      .rsp_tag_out   (rsp_tag_out),
      .rsp_ready_out (rsp_ready_out)
   );

   // Drives one batch, updates the memory model and pushes the expected response.
   task automatic send(input logic [3:0] v, input logic [3:0] rw,
                       input logic [3:0][3:0] be, input logic [3:0][29:0] a,
                       input logic [3:0][31:0] d, input logic [7:0] t0,
                       input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] t3);
      rsp_t        e;
      int          n;
      bit          got;
      logic [31:0] w;
      n = 0;
      while (req_ready_in !== 4'hF && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) begin
         tests_run++; tests_failed++;
         $display("FAIL send_ready: ready=%h required=f", req_ready_in);
      end
      req_valid_in  = v;
      req_rw_in     = rw;
      req_byteen_in = be;
      req_addr_in   = a;
      req_data_in   = d;
      req_tag_in    = {t3, t2, t1, t0};
      e = '0;
      got = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i] && !got) begin
            e.tag = req_tag_in[i];
            got = 1;
         end
         if (v[i] && !rw[i]) begin
            e.tmask[i] = 1'b1;
            e.data[i] = mdl.exists(int'(a[i])) ? mdl[int'(a[i])] : 32'h0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (v[i] && rw[i]) begin
            w = mdl.exists(int'(a[i])) ? mdl[int'(a[i])] : 32'h0;
            for (int j = 0; j < 4; j++) begin
               if (be[i][j]) w[8*j +: 8] = d[i][8*j +: 8];
            end
            mdl[int'(a[i])] = w;
         end
      end
      if (e.tmask != 4'h0) sb.push_back(e);
      @(posedge clk); #1;
      req_valid_in = 4'h0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid_out && n < 20) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic wait_idle(output int n, output bit saw);
      n = 0;
      saw = 0;
      while (req_ready_in !== 4'hF && n < 20) begin
         @(posedge clk); #1; n++;
         if (rsp_valid_out) saw = 1;
      end
   endtask

   task automatic test_reset;
      #2;
      tests_run++;
      if (req_ready_in !== 4'h0 || rsp_valid_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hs: ready=%h valid=%b required 0/0",
                  req_ready_in, rsp_valid_out);
      end
      tests_run++;
      if (rsp_tmask_out !== 4'h0 || rsp_data_out !== '0 || rsp_tag_out !== 8'h0) begin
         tests_failed++;
         $display("FAIL reset_rsp: tmask=%h data=%h tag=%h required 0",
                  rsp_tmask_out, rsp_data_out, rsp_tag_out);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (req_ready_in !== 4'hF) begin
         tests_failed++;
         $display("FAIL reset_release: ready=%h required=f", req_ready_in);
      end
   endtask

   task automatic test_write_read;
      int   n;
      bit   saw;
      rsp_t e;
      send(4'hF, 4'hF, {4'hF, 4'hF, 4'hF, 4'hF}, {30'd3, 30'd2, 30'd1, 30'd0},
           {32'h44, 32'h33, 32'h22, 32'h11}, 8'h01, 8'h02, 8'h03, 8'h04);
      wait_idle(n, saw);
      tests_run++;
      if (n !== 1 || saw) begin
         tests_failed++;
         $display("FAIL wr_idle: cycles=%0d rsp=%b required 1/0", n, saw);
      end
      send(4'hF, 4'h0, '0, {30'd3, 30'd2, 30'd1, 30'd0}, '0,
           8'h10, 8'h20, 8'h30, 8'h40);
      wait_rsp(n);
      tests_run++;
      if (n !== 1) begin
         tests_failed++;
         $display("FAIL rd_latency: cycles=%0d required=1", n);
      end
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL rd_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_tmask_out !== e.tmask || rsp_data_out !== e.data ||
             rsp_tag_out !== e.tag || rsp_data_out[3] !== 32'h44) begin
            tests_failed++;
            $display("FAIL rd_rsp: got %h/%h/%h required %h/%h/%h", rsp_tmask_out,
                     rsp_data_out, rsp_tag_out, e.tmask, e.data, e.tag);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_conflict;
      int   n;
      bit   saw;
      rsp_t e;
      send(4'hF, 4'hF, {4'hF, 4'hF, 4'hF, 4'hF}, {30'd12, 30'd8, 30'd4, 30'd0},
           {32'hD0D0_000C, 32'hC0C0_0008, 32'hB0B0_0004, 32'hA0A0_0000},
           8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle(n, saw);
      tests_run++;
      if (n !== 4 || saw) begin
         tests_failed++;
         $display("FAIL conf_wr: cycles=%0d rsp=%b required 4/0", n, saw);
      end
      send(4'hF, 4'h0, '0, {30'd12, 30'd8, 30'd4, 30'd0}, '0,
           8'h21, 8'h22, 8'h23, 8'h24);
      wait_rsp(n);
      tests_run++;
      if (n !== 4) begin
         tests_failed++;
         $display("FAIL conf_latency: cycles=%0d required=4", n);
      end
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL conf_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_tmask_out !== e.tmask || rsp_data_out !== e.data ||
             rsp_tag_out !== 8'h21) begin
            tests_failed++;
            $display("FAIL conf_rsp: got %h/%h/%h required %h/%h/21", rsp_tmask_out,
                     rsp_data_out, rsp_tag_out, e.tmask, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bcast;
      int   n;
      int   lat;
      rsp_t e;
`ifdef SMEM_BCAST_EN
      lat = 1;
`else
      lat = 4;
`endif
      send(4'hF, 4'h0, '0, {30'd8, 30'd8, 30'd8, 30'd8}, '0,
           8'h31, 8'h32, 8'h33, 8'h34);
      wait_rsp(n);
      tests_run++;
      if (n !== lat) begin
         tests_failed++;
         $display("FAIL bcast_latency: cycles=%0d required=%0d", n, lat);
      end
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL bcast_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_tmask_out !== e.tmask || rsp_data_out !== e.data ||
             rsp_tag_out !== e.tag) begin
            tests_failed++;
            $display("FAIL bcast_rsp: got %h/%h required %h/%h",
                     rsp_tmask_out, rsp_data_out, e.tmask, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_same_word;
      int   n;
      bit   saw;
      rsp_t e;
      send(4'hA, 4'hA, {4'hF, 4'h0, 4'hF, 4'h0}, {30'd5, 30'd0, 30'd5, 30'd0},
           {32'hBB, 32'h0, 32'hAA, 32'h0}, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle(n, saw);
      tests_run++;
      if (n !== 2 || saw) begin
         tests_failed++;
         $display("FAIL same_wr: cycles=%0d rsp=%b required 2/0", n, saw);
      end
      send(4'h1, 4'h0, '0, {30'd0, 30'd0, 30'd0, 30'd5}, '0,
           8'h41, 8'h00, 8'h00, 8'h00);
      wait_rsp(n);
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL same_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_data_out !== e.data || rsp_data_out[0] !== 32'hBB ||
             rsp_tmask_out !== 4'h1) begin
            tests_failed++;
            $display("FAIL same_rsp: got %h required %h", rsp_data_out, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_byteen;
      int   n;
      bit   saw;
      rsp_t e;
      send(4'h1, 4'h1, {4'h0, 4'h0, 4'h0, 4'hF}, {30'd0, 30'd0, 30'd0, 30'd6},
           {32'h0, 32'h0, 32'h0, 32'h12345678}, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle(n, saw);
      send(4'h1, 4'h1, {4'h0, 4'h0, 4'h0, 4'h1}, {30'd0, 30'd0, 30'd0, 30'd6},
           {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle(n, saw);
      send(4'h1, 4'h0, '0, {30'd0, 30'd0, 30'd0, 30'd6}, '0,
           8'h51, 8'h00, 8'h00, 8'h00);
      wait_rsp(n);
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL byteen_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_data_out !== e.data || rsp_data_out[0] !== 32'h123456FF) begin
            tests_failed++;
            $display("FAIL byteen_rsp: got %h required %h", rsp_data_out, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mixed_stall;
      int               n;
      bit               saw;
      rsp_t             e;
      logic [3:0]       s_tmask;
      logic [3:0][31:0] s_data;
      logic [7:0]       s_tag;
      send(4'h1, 4'h1, {4'h0, 4'h0, 4'h0, 4'hF}, {30'd0, 30'd0, 30'd0, 30'd7},
           {32'h0, 32'h0, 32'h0, 32'hCAFEF00D}, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle(n, saw);
      rsp_ready_out = 1'b0;
      send(4'h5, 4'h4, {4'h0, 4'hF, 4'h0, 4'h0}, {30'd3, 30'd9, 30'd2, 30'd7},
           {32'h0, 32'h600DBEEF, 32'h0, 32'h0}, 8'h5A, 8'h66, 8'h77, 8'h88);
      wait_rsp(n);
      s_tmask = rsp_tmask_out;
      s_data  = rsp_data_out;
      s_tag   = rsp_tag_out;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         tests_run++;
         if (rsp_valid_out !== 1'b1 || req_ready_in !== 4'h0 ||
             rsp_tmask_out !== s_tmask || rsp_data_out !== s_data ||
             rsp_tag_out !== s_tag) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: valid=%b ready=%h tmask=%h tag=%h",
                     c, rsp_valid_out, req_ready_in, rsp_tmask_out, rsp_tag_out);
         end
      end
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL mixed_rsp: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_tmask_out !== e.tmask || rsp_data_out !== e.data ||
             rsp_tag_out !== e.tag || rsp_tag_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL mixed_rsp: got %h/%h/%h required %h/%h/%h", rsp_tmask_out,
                     rsp_data_out, rsp_tag_out, e.tmask, e.data, e.tag);
         end
      end
      rsp_ready_out = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid_out !== 1'b0 || req_ready_in !== 4'hF) begin
         tests_failed++;
         $display("FAIL mixed_release: valid=%b ready=%h required 0/f",
                  rsp_valid_out, req_ready_in);
      end
      send(4'h1, 4'h0, '0, {30'd0, 30'd0, 30'd0, 30'd9}, '0,
           8'h61, 8'h00, 8'h00, 8'h00);
      wait_rsp(n);
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL mixed_wr: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (rsp_data_out !== e.data || rsp_data_out[0] !== 32'h600DBEEF) begin
            tests_failed++;
            $display("FAIL mixed_wr: got %h required %h", rsp_data_out, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      bit saw;
      send(4'hF, 4'h0, '0, {30'd12, 30'd8, 30'd4, 30'd0}, '0,
           8'h71, 8'h72, 8'h73, 8'h74);
      void'(sb.pop_back());
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (rsp_valid_out !== 1'b0 || req_ready_in !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_mid: valid=%b ready=%h required 0/0",
                  rsp_valid_out, req_ready_in);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (req_ready_in !== 4'hF || rsp_tmask_out !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_release: ready=%h tmask=%h required f/0",
                  req_ready_in, rsp_tmask_out);
      end
      saw = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (rsp_valid_out) saw = 1;
      end
      tests_run++;
      if (saw || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL reset_mid_drop: rsp=%b pending=%0d required 0/0",
                  saw, sb.size());
      end
   endtask

   initial begin
      req_valid_in  = '0;
      req_rw_in     = '0;
      req_byteen_in = '0;
      req_addr_in   = '0;
      req_data_in   = '0;
      req_tag_in    = '0;
      rsp_ready_out = 1'b1;
      test_reset();
      test_write_read();
      test_conflict();
      test_bcast();
      test_same_word();
      test_byteen();
      test_mixed_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
